// File: rtl/axi_mm_mem_pkg.sv
// Shared definitions for the AXI-MM memory bank: controller state encoding
// and the byte-lane count helper used to size write strobes.
package axi_mm_mem_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } memState_e;

    function automatic int byteLanes(input int dataWidth);
        return dataWidth / 8;
    endfunction

endpackage

// File: rtl/axi_mm_mem_init_ctrl.sv
// Zero-fill sweep controller. After reset it walks the word address from 0 to
// MEM_DEPTH-1, issuing one zero write per cycle, then parks in RUN where the
// bank accepts user traffic.
module axi_mm_mem_init_ctrl
    import axi_mm_mem_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              init_busy_o,
    output logic [ADDR_W-1:0] init_addr_o,
    output logic              init_we_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    memState_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // State and sweep counter registers; reset restarts the sweep at word 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: zero one word per cycle, leave INIT after the last word.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        init_we_o = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                init_we_o = ~rst_i;
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign init_busy_o = (state_q == ST_INIT);
    assign init_addr_o = cnt_q;

endmodule

// File: rtl/axi_mm_mem_bank.sv
// Byte-addressable-lane memory bank with a zero-fill sweep after reset, one
// write port with byte strobes and one registered read port (1-cycle latency).
// Out-of-range writes are dropped with a werr pulse; out-of-range reads
// return zero with rerr set.
// Build option: define AXI_MM_MEM_WR_FWD_EN to return byte-merged new data on
// a same-address read/write collision; otherwise collisions read the old word.
module axi_mm_mem_bank
    import axi_mm_mem_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int OPT_MEM_ADDR_BITS  = 9,
    parameter int MEM_DEPTH          = 1000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wen,
    input  logic [OPT_MEM_ADDR_BITS:0]      waddr,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb,
    output logic                            werr,
    input  logic                            ren,
    input  logic [OPT_MEM_ADDR_BITS:0]      raddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   rdata,
    output logic                            rvalid,
    output logic                            rerr,
    output logic                            init_busy
);

    localparam int DW     = C_S_AXI_DATA_WIDTH;
    localparam int ADDR_W = OPT_MEM_ADDR_BITS + 1;
    localparam int STRB_W = byteLanes(C_S_AXI_DATA_WIDTH);

    logic [DW-1:0]     mem [MEM_DEPTH];

    logic              initWe;
    logic [ADDR_W-1:0] initAddr;
    logic              runActive;
    logic              wrAccept, wrInRange;
    logic              rdAccept, rdInRange;
    logic              memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [DW-1:0]     memWdata;
    logic [STRB_W-1:0] memStrb;

    logic [DW-1:0]     memRd_q;
    logic              rdZero_q;
    logic              rvalid_q;
    logic              rerr_q;
    logic              werr_q;
    logic [DW-1:0]     rdMerged;

    axi_mm_mem_init_ctrl #(
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_init_ctrl (
        .clk_i       (clk),
        .rst_i       (rst),
        .init_busy_o (init_busy),
        .init_addr_o (initAddr),
        .init_we_o   (initWe)
    );

    assign runActive = ~init_busy & ~rst;
    assign wrInRange = (32'(waddr) < 32'(MEM_DEPTH));
    assign rdInRange = (32'(raddr) < 32'(MEM_DEPTH));
    assign wrAccept  = runActive & wen;
    assign rdAccept  = runActive & ren;

    assign memWe    = initWe | (wrAccept & wrInRange);
    assign memAddr  = init_busy ? initAddr : waddr;
    assign memWdata = init_busy ? '0 : wdata;
    assign memStrb  = init_busy ? '1 : wstrb;

    // Single write port shared by the zero-fill sweep and user writes.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (memStrb[i]) begin
                    mem[memAddr][i*8 +: 8] <= memWdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered read port, left unreset so it maps onto the RAM output register.
    always_ff @(posedge clk) begin
        if (rdAccept && rdInRange) begin
            memRd_q <= mem[raddr];
        end
    end

    // Response strobes and the zero-data flag that also covers the reset value.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            werr_q   <= 1'b0;
            rdZero_q <= 1'b1;
        end else begin
            rvalid_q <= rdAccept;
            rerr_q   <= rdAccept & ~rdInRange;
            werr_q   <= wrAccept & ~wrInRange;
            if (rdAccept) begin
                rdZero_q <= ~rdInRange;
            end
        end
    end

`ifdef AXI_MM_MEM_WR_FWD_EN
    logic              fwdHit_q;
    logic [DW-1:0]     fwdData_q;
    logic [STRB_W-1:0] fwdStrb_q;

    // Capture a same-address write alongside each accepted read for merging.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwdHit_q <= 1'b0;
        end else if (rdAccept) begin
            fwdHit_q <= wrAccept & wrInRange & rdInRange & (waddr == raddr);
        end
        if (rdAccept) begin
            fwdData_q <= wdata;
            fwdStrb_q <= wstrb;
        end
    end

    // Overlay the colliding write's enabled lanes onto the old RAM word.
    always_comb begin
        rdMerged = memRd_q;
        if (fwdHit_q) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (fwdStrb_q[i]) begin
                    rdMerged[i*8 +: 8] = fwdData_q[i*8 +: 8];
                end
            end
        end
        rdata = rdZero_q ? '0 : rdMerged;
    end
`else
    // Read-first: a colliding read sees the word as it was before the write.
    always_comb begin
        rdMerged = memRd_q;
        rdata    = rdZero_q ? '0 : rdMerged;
    end
`endif

    assign rvalid = rvalid_q;
    assign rerr   = rerr_q;
    assign werr   = werr_q;

endmodule

// File: tb/tb_axi_mm_mem_bank.sv
// Scoreboard testbench for axi_mm_mem_bank: stimulus pushes expected read and
// werr responses computed from a word-array model; a negedge monitor pops and
// compares them as the DUT presents responses.
module tb_axi_mm_mem_bank;

    localparam int DW    = 32;
    localparam int AW    = 10;
    localparam int DEPTH = 1000;
    localparam int SW    = DW / 8;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rdExp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wen = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          werr;
    logic          ren = 1'b0;
    logic [AW-1:0] raddr = '0;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          rerr;
    logic          init_busy;

    logic [31:0] model [0:DEPTH-1];
    rdExp_t      rdQ[$];
    int          werrQ[$];
    rdExp_t      monExp;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          holdCheckEn = 1'b0;
    logic [31:0] holdExp = '0;
    int          sweepLen;
    bit          busyStayed;

    axi_mm_mem_bank #(
        .C_S_AXI_DATA_WIDTH (DW),
        .OPT_MEM_ADDR_BITS  (AW - 1),
        .MEM_DEPTH          (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .waddr     (waddr),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .werr      (werr),
        .ren       (ren),
        .raddr     (raddr),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .rerr      (rerr),
        .init_busy (init_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] st);
        logic [31:0] res = old;
        for (int i = 0; i < 4; i++) begin
            if (st[i]) res[i*8 +: 8] = nw[i*8 +: 8];
        end
        return res;
    endfunction

    function automatic int pickAddr();
        if ($urandom_range(0, 9) == 0) return int'($urandom_range(DEPTH, 1023));
        return int'($urandom_range(0, DEPTH - 1));
    endfunction

    task automatic modelClear();
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
    endtask

    // One RUN-mode cycle: predict responses from the model, then drive the DUT.
    task automatic applyStimulus(input bit w, input int wa, input logic [31:0] wd,
                                 input logic [3:0] ws, input bit r, input int ra);
        rdExp_t e;
        wen   = w;
        waddr = AW'(wa);
        wdata = wd;
        wstrb = ws;
        ren   = r;
        raddr = AW'(ra);
        if (r) begin
            e.cyc = cyc + 1;
            if (ra >= DEPTH) begin
                e.data = 32'h0;
                e.err  = 1'b1;
            end else begin
                e.err  = 1'b0;
                e.data = model[ra];
`ifdef AXI_MM_MEM_WR_FWD_EN
                if (w && wa == ra) e.data = merge(model[ra], wd, ws);
`endif
            end
            rdQ.push_back(e);
        end
        if (w) begin
            if (wa < DEPTH) model[wa] = merge(model[wa], wd, ws);
            else werrQ.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        wen = 1'b0;
        ren = 1'b0;
    endtask

    // Count cycles of init_busy, optionally throwing ignored traffic at the bank.
    task automatic waitSweep(input int junkCycles, output int n);
        n = 0;
        while (init_busy === 1'b1 && n < 5000) begin
            if (n < junkCycles) begin
                wen   = 1'b1;
                waddr = AW'($urandom_range(0, 1023));
                wdata = $urandom;
                wstrb = 4'hF;
                ren   = 1'b1;
                raddr = AW'($urandom_range(0, 1023));
            end else begin
                wen = 1'b0;
                ren = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        wen = 1'b0;
        ren = 1'b0;
    endtask

    // Monitor: match every rvalid/werr pulse against the scoreboard queues.
    always @(negedge clk) begin
        if (rvalid === 1'b1) begin
            if (rdQ.size() == 0) begin
                checkOutput("rvalid_unexpected", 1, 0);
            end else begin
                monExp = rdQ.pop_front();
                checkOutput("rd_cycle", cyc, monExp.cyc);
                checkOutput("rdata", rdata, monExp.data);
                checkOutput("rerr", rerr, monExp.err);
                holdExp = monExp.data;
            end
        end else if (!rst && holdCheckEn) begin
            checkOutput("rdata_hold", rdata, holdExp);
            if (rerr !== 1'b0) checkOutput("rerr_idle", rerr, 0);
        end
        if (werr === 1'b1) begin
            if (werrQ.size() == 0) checkOutput("werr_unexpected", 1, 0);
            else checkOutput("werr_cycle", cyc, werrQ.pop_front());
        end
    end

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_rvalid", rvalid, 0);
        checkOutput("reset_rerr", rerr, 0);
        checkOutput("reset_werr", werr, 0);
        checkOutput("reset_init_busy", init_busy, 1);
        checkOutput("reset_rdata", rdata, 0);
        rst = 1'b0;
        holdExp = '0;
        holdCheckEn = 1'b1;

        $display("[TB] initial sweep with ignored traffic");
        waitSweep(500, sweepLen);
        checkOutput("sweep_len", sweepLen, DEPTH);
        modelClear();

        $display("[TB] read back every word");
        for (int a = 0; a < DEPTH; a++) applyStimulus(0, 0, 0, 4'h0, 1, a);

        $display("[TB] byte strobes");
        applyStimulus(1, 5, 32'hAABBCCDD, 4'hF, 0, 0);
        applyStimulus(1, 5, 32'h11223344, 4'b0101, 0, 0);
        applyStimulus(0, 0, 0, 4'h0, 1, 5);

        $display("[TB] range boundaries");
        applyStimulus(1, 1000, 32'hDEADBEEF, 4'hF, 0, 0);
        applyStimulus(0, 0, 0, 4'h0, 1, 1000);
        applyStimulus(0, 0, 0, 4'h0, 1, 1023);
        applyStimulus(1, 999, 32'h5A5A5A5A, 4'hF, 1, 999);
        applyStimulus(0, 0, 0, 4'h0, 1, 999);
        applyStimulus(0, 0, 0, 4'h0, 1, 0);

        $display("[TB] collisions and independent ports");
        applyStimulus(1, 7, 32'h0, 4'hF, 0, 0);
        applyStimulus(1, 7, 32'hFFFFFFFF, 4'hF, 1, 7);
        applyStimulus(1, 7, 32'h12345678, 4'b0011, 1, 7);
        applyStimulus(0, 0, 0, 4'h0, 1, 7);
        applyStimulus(1, 20, 32'hCAFEF00D, 4'hF, 1, 21);
        applyStimulus(0, 0, 0, 4'h0, 1, 20);

        $display("[TB] back-to-back reads");
        for (int a = 0; a < 16; a++) applyStimulus(1, a, a * 3, 4'hF, 0, 0);
        for (int a = 0; a < 16; a++) applyStimulus(0, 0, 0, 4'h0, 1, a);

        $display("[TB] random traffic");
        repeat (400) begin
            int wa;
            int ra;
            wa = pickAddr();
            ra = ($urandom_range(0, 3) == 0) ? wa : pickAddr();
            applyStimulus(bit'($urandom_range(0, 1)), wa, $urandom, 4'($urandom_range(0, 15)),
                          bit'($urandom_range(0, 1)), ra);
        end
        repeat (3) @(posedge clk);
        #1;

        $display("[TB] reset during a read, then mid-sweep reset");
        ren   = 1'b1;
        raddr = AW'(3);
        rst   = 1'b1;
        holdExp = '0;
        @(posedge clk);
        #1;
        ren = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        busyStayed = 1'b1;
        repeat (500) begin
            @(posedge clk);
            #1;
            if (init_busy !== 1'b1) busyStayed = 1'b0;
        end
        checkOutput("busy_first_half", busyStayed, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("busy_in_reset", init_busy, 1);
        rst = 1'b0;
        waitSweep(0, sweepLen);
        checkOutput("sweep_restart_len", sweepLen, DEPTH);
        modelClear();
        for (int a = 0; a < 16; a++) applyStimulus(0, 0, 0, 4'h0, 1, a);
        for (int a = 990; a < DEPTH; a++) applyStimulus(0, 0, 0, 4'h0, 1, a);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rd_queue_empty", rdQ.size(), 0);
        checkOutput("werr_queue_empty", werrQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_mm_mem_bank.md
AXI_MM_MEM_BANK -- requirements
Module: axi_mm_mem_bank

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, data width in bits; legal values are 32 or 64.
REQ-002 SHALL have parameter OPT_MEM_ADDR_BITS, default 9, so the word address width is OPT_MEM_ADDR_BITS+1.
REQ-003 SHALL have parameter MEM_DEPTH, default 1000, number of implemented words; legal range is 1..2^(OPT_MEM_ADDR_BITS+1).
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  the single clock; all state updates on its rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 wen  in  1  write request.
REQ-008 waddr  in  OPT_MEM_ADDR_BITS+1  write word address.
REQ-009 wdata  in  C_S_AXI_DATA_WIDTH  write data.
REQ-010 wstrb  in  C_S_AXI_DATA_WIDTH/8  byte-lane enables.
REQ-011 werr  out  1  one-cycle pulse marking a dropped out-of-range write.
REQ-012 ren  in  1  read request.
REQ-013 raddr  in  OPT_MEM_ADDR_BITS+1  read word address.
REQ-014 rdata  out  C_S_AXI_DATA_WIDTH  registered read data.
REQ-015 rvalid  out  1  one-cycle pulse marking rdata valid.
REQ-016 rerr  out  1  qualifies rvalid; marks an out-of-range read.
REQ-017 init_busy  out  1  high while the zero-fill sweep runs.

Function
REQ-018 SHALL use a state machine with states INIT and RUN; rst forces INIT; INIT goes to RUN after the write to word MEM_DEPTH-1.
REQ-019 In INIT, SHALL write zero to word N on the Nth cycle after rst deasserts, N counting up from 0; the sweep takes MEM_DEPTH cycles.
REQ-020 init_busy SHALL be 1 exactly while in INIT.
REQ-021 In INIT, wen and ren SHALL be ignored and not queued; rvalid and werr SHALL stay 0.
REQ-022 In RUN, when wen=1 and waddr<MEM_DEPTH, each byte lane i with wstrb[i]=1 SHALL update at that clock edge; lanes with wstrb[i]=0 keep their old value.
REQ-023 In RUN, when wen=1 and waddr>=MEM_DEPTH, SHALL leave the memory unchanged and pulse werr=1 on the next cycle.
REQ-024 In RUN, when ren=1, SHALL assert rvalid for one cycle exactly 1 cycle later, with rdata holding the word at raddr.
REQ-025 When ren=1 and raddr>=MEM_DEPTH, the response SHALL be rdata=0 with rerr=1; otherwise rerr=0.
REQ-026 ren may be asserted every cycle; SHALL accept one read per cycle with no bubbles.
REQ-027 rdata SHALL hold its last value when rvalid=0.
REQ-028 When wen and ren hit the same in-range address in the same cycle, the read result is set by REQ-033/REQ-034.
REQ-029 wen and ren to different addresses in the same cycle SHALL both complete without interference.

Reset
REQ-030 At reset, the following SHALL be set: rdata=0, rvalid=0, rerr=0, werr=0, init_busy=1, sweep counter=0, state=INIT.
REQ-031 If rst is asserted mid-sweep or mid-read, SHALL drop any pending response and restart the sweep at word 0 on the cycle after rst deasserts.

Configuration
REQ-032 Macro AXI_MM_MEM_WR_FWD_EN SHALL select the read-during-write behaviour.
REQ-033 With the macro defined, a same-address collision SHALL return the byte-merged new data: wstrb-enabled lanes from wdata, the other lanes from old memory.
REQ-034 Without the macro, a same-address collision SHALL return the old memory contents (read-first).

Structure
REQ-035 Package axi_mm_mem_pkg SHALL hold the INIT/RUN state encoding and the byte-lane count function or constant.
REQ-036 Sub-module axi_mm_mem_init_ctrl SHALL contain the sweep counter and the INIT/RUN state machine, and output init_busy, the init address and the init write enable.
REQ-037 The memory array SHALL be inferable as block RAM: one write port and one registered read port.

Verification
REQ-038 Reset: rst for 2 cycles then release, MEM_DEPTH=1000 -> init_busy high for exactly 1000 cycles, then a read of every address returns 0.
REQ-039 Byte strobe: write 0xAABBCCDD to addr 5, then write 0x11223344 with wstrb=4'b0101 -> read of addr 5 returns 0xAA22CC44, rvalid 1 cycle after ren.
REQ-040 Range: write to addr 1000 -> werr pulse, no memory change; read of addr 1000 -> rvalid=1, rerr=1, rdata=0.
REQ-041 Collision: addr 7 holds 0x0; write 0xFFFFFFFF with full strobes and read addr 7 in the same cycle -> 0xFFFFFFFF if AXI_MM_MEM_WR_FWD_EN is defined, else 0x0.
REQ-042 Mid-sweep reset: assert rst at sweep word 500 -> init_busy stays high and the sweep restarts from 0, 1000 cycles total.
REQ-043 Throughput: ren every cycle over addrs 0..15 after writing pattern addr*3 -> 16 consecutive rvalid pulses with data 0,3,6,...,45.
